// File: rtl/isa_bus_pkg.sv
// Shared definitions for the ISA bus arbiter: state encoding, engine command
// bit positions, default widths and small encoding helpers.
package isa_bus_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 8;
  localparam int CMD_READ_BIT  = 0;
  localparam int CMD_WRITE_BIT = 1;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_t;

  // Engine command word: exactly one of read/write set, upper bits zero.
  function automatic logic [7:0] make_cmd(input logic wr);
    logic [7:0] cmd;
    cmd = 8'h00;
    cmd[CMD_WRITE_BIT] = wr;
    cmd[CMD_READ_BIT]  = ~wr;
    return cmd;
  endfunction

  function automatic logic [1:0] port_onehot(input logic port);
    return {port, ~port};
  endfunction

endpackage

// File: rtl/isa_rr_arb2.sv
// Two-way round-robin picker; the last-granted pointer moves only when a
// transaction is acknowledged.
module isa_rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       ack_fire,
  input  logic       ack_port,
  output logic       winner
);

  logic r_last;

  // Last-granted pointer; reset value 1 makes port 0 preferred.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (ack_fire) begin
      r_last <= ack_port;
    end else begin
      r_last <= r_last;
    end
  end

  // Winner select: a lone request wins, contention goes to the port not granted last.
  always_comb begin
    case (req)
      2'b01:   winner = 1'b0;
      2'b10:   winner = 1'b1;
      2'b11:   winner = ~r_last;
      default: winner = 1'b0;
    endcase
  end

endmodule

// File: rtl/isa_bus_arbiter.sv
// Shares the ISA I/O bus-cycle engine between two requesters.
// Optional macro BUS_TIMEOUT_EN adds an abort/err path for stalled cycles.
module isa_bus_arbiter
  import isa_bus_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        req_wr,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        ack,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [7:0]        eng_control,
  output logic [ADDR_W-1:0] eng_addr,
  output logic [DATA_W-1:0] eng_wdata,
  input  logic [DATA_W-1:0] eng_rdata,
  input  logic              eng_control_reset_n,
  output logic              eng_abort,
  output logic [1:0]        grant_debug
);

  arb_state_t        r_state, w_state_nxt;
  logic              r_winner, w_winner_nxt;
  logic              r_wr, w_wr_nxt;
  logic              r_done_n;
  logic [7:0]        r_ctrl, w_ctrl_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic [1:0]        r_ack, w_ack_nxt;
  logic [1:0]        r_grant, w_grant_nxt;
  logic              w_fire;
  logic              w_rr_winner;

  isa_rr_arb2 u_rr (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .ack_fire (w_fire),
    .ack_port (r_winner),
    .winner   (w_rr_winner)
  );

`ifdef BUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err, w_err_nxt;
  logic             r_abort, w_abort_nxt;

  // WAIT-cycle counter, zeroed as the command is issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (r_state == ARB_ISSUE) begin
      r_cnt <= '0;
    end else if (r_state == ARB_WAIT) begin
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end
`endif

  // Next-state and next-output logic for the arbiter FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_winner_nxt = r_winner;
    w_wr_nxt     = r_wr;
    w_ctrl_nxt   = r_ctrl;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_rdata_nxt  = r_rdata;
    w_ack_nxt    = 2'b00;
    w_grant_nxt  = r_grant;
    w_fire       = 1'b0;
`ifdef BUS_TIMEOUT_EN
    w_err_nxt    = 1'b0;
    w_abort_nxt  = 1'b0;
`endif
    case (r_state)
      ARB_IDLE: begin
        if (|req) begin
          w_state_nxt  = ARB_ISSUE;
          w_winner_nxt = w_rr_winner;
          w_wr_nxt     = req_wr[w_rr_winner];
          w_addr_nxt   = w_rr_winner ? req_addr1 : req_addr0;
          w_wdata_nxt  = w_rr_winner ? req_wdata1 : req_wdata0;
          w_grant_nxt  = port_onehot(w_rr_winner);
        end else begin
          w_state_nxt  = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        w_ctrl_nxt  = make_cmd(r_wr);
        w_state_nxt = ARB_WAIT;
      end
      ARB_WAIT: begin
        // Completion is checked first so it beats a coincident timeout.
        if (!r_done_n) begin
          w_fire      = 1'b1;
          w_ctrl_nxt  = 8'h00;
          w_rdata_nxt = r_wr ? r_rdata : eng_rdata;
          w_ack_nxt   = port_onehot(r_winner);
          w_grant_nxt = 2'b00;
          w_state_nxt = ARB_IDLE;
`ifdef BUS_TIMEOUT_EN
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_fire      = 1'b1;
          w_abort_nxt = 1'b1;
          w_err_nxt   = 1'b1;
          w_ctrl_nxt  = 8'h00;
          w_rdata_nxt = {DATA_W{1'b1}};
          w_ack_nxt   = port_onehot(r_winner);
          w_grant_nxt = 2'b00;
          w_state_nxt = ARB_IDLE;
`endif
        end else begin
          w_state_nxt = ARB_WAIT;
        end
      end
      default: begin
        w_ctrl_nxt  = 8'h00;
        w_grant_nxt = 2'b00;
        w_state_nxt = ARB_IDLE;
      end
    endcase
  end

  // State and output registers; the completion pulse is sampled one cycle late.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ARB_IDLE;
      r_winner <= 1'b0;
      r_wr     <= 1'b0;
      r_done_n <= 1'b1;
      r_ctrl   <= 8'h00;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_ack    <= 2'b00;
      r_grant  <= 2'b00;
`ifdef BUS_TIMEOUT_EN
      r_err    <= 1'b0;
      r_abort  <= 1'b0;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_winner <= w_winner_nxt;
      r_wr     <= w_wr_nxt;
      r_done_n <= eng_control_reset_n;
      r_ctrl   <= w_ctrl_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_rdata  <= w_rdata_nxt;
      r_ack    <= w_ack_nxt;
      r_grant  <= w_grant_nxt;
`ifdef BUS_TIMEOUT_EN
      r_err    <= w_err_nxt;
      r_abort  <= w_abort_nxt;
`endif
    end
  end

  assign ack         = r_ack;
  assign rdata       = r_rdata;
  assign eng_control = r_ctrl;
  assign eng_addr    = r_addr;
  assign eng_wdata   = r_wdata;
  assign grant_debug = r_grant;
`ifdef BUS_TIMEOUT_EN
  assign err         = r_err;
  assign eng_abort   = r_abort;
`else
  assign err         = 1'b0;
  assign eng_abort   = 1'b0;
`endif

endmodule

// File: tb/tb_isa_bus_arbiter.sv
// Randomized self-checking bench for isa_bus_arbiter with a transaction-level
// round-robin/engine reference model.
module tb_isa_bus_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [1:0]        req;
  logic [1:0]        req_wr;
  logic [ADDR_W-1:0] req_addr0, req_addr1;
  logic [DATA_W-1:0] req_wdata0, req_wdata1;
  logic [1:0]        ack;
  logic              err;
  logic [DATA_W-1:0] rdata;
  logic [7:0]        eng_control;
  logic [ADDR_W-1:0] eng_addr;
  logic [DATA_W-1:0] eng_wdata;
  logic [DATA_W-1:0] eng_rdata;
  logic              eng_control_reset_n;
  logic              eng_abort;
  logic [1:0]        grant_debug;

  isa_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(32)) dut (
    .clk                 (clk),
    .reset               (reset),
    .req                 (req),
    .req_wr              (req_wr),
    .req_addr0           (req_addr0),
    .req_addr1           (req_addr1),
    .req_wdata0          (req_wdata0),
    .req_wdata1          (req_wdata1),
    .ack                 (ack),
    .err                 (err),
    .rdata               (rdata),
    .eng_control         (eng_control),
    .eng_addr            (eng_addr),
    .eng_wdata           (eng_wdata),
    .eng_rdata           (eng_rdata),
    .eng_control_reset_n (eng_control_reset_n),
    .eng_abort           (eng_abort),
    .grant_debug         (grant_debug)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int                last_port;
  logic [DATA_W-1:0] m_rdata;
  logic [1:0]        pending;
  logic              p_wr    [2];
  logic [ADDR_W-1:0] p_addr  [2];
  logic [DATA_W-1:0] p_wdata [2];

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [1:0] pend);
    if (pend == 2'b11) return 1 - last_port;
    else if (pend[1]) return 1;
    else return 0;
  endfunction

  function automatic logic [1:0] onehot(input int p);
    return (p == 1) ? 2'b10 : 2'b01;
  endfunction

  function automatic logic [7:0] exp_cmd(input logic wr);
    return wr ? 8'h02 : 8'h01;
  endfunction

  task automatic set_port(input int p, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
    p_wr[p] = wr; p_addr[p] = a; p_wdata[p] = d;
    pending[p] = 1'b1;
    req[p] = 1'b1;
    req_wr[p] = wr;
    if (p == 0) begin req_addr0 = a; req_wdata0 = d; end
    else begin req_addr1 = a; req_wdata1 = d; end
  endtask

  task automatic set_random_port(input int p);
    set_port(p, 1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom));
  endtask

  // Serve every pending request; called right after a negedge at which the arbiter is idle.
  task automatic serve_all(input int rd_fix);
    int w, off;
    logic [DATA_W-1:0] rd;
    while (pending != 2'b00) begin
      w   = pick(pending);
      off = $urandom_range(0, 6);
      rd  = (rd_fix >= 0) ? DATA_W'(rd_fix) : DATA_W'($urandom);
      @(negedge clk);
      check_value("ctl_idle_before_cmd", {24'h0, eng_control}, 32'h0);
      check_value("grant_at_issue", {30'h0, grant_debug}, {30'h0, onehot(w)});
      if (off == 0) begin eng_control_reset_n = 1'b0; eng_rdata = rd; end
      for (int n = 2; n <= off + 3; n++) begin
        @(negedge clk);
        if (n == off + 2) eng_control_reset_n = 1'b1;
        if (n == off + 1) begin eng_control_reset_n = 1'b0; eng_rdata = rd; end
        if (n == 2) begin
          check_value("eng_control_cmd", {24'h0, eng_control}, {24'h0, exp_cmd(p_wr[w])});
          check_value("eng_addr", {22'h0, eng_addr}, {22'h0, p_addr[w]});
          check_value("eng_wdata", {24'h0, eng_wdata}, {24'h0, p_wdata[w]});
        end else if (n < off + 3) begin
          check_value("eng_control_hold", {24'h0, eng_control}, {24'h0, exp_cmd(p_wr[w])});
        end
        if (n < off + 3) begin
          check_value("ack_early", {30'h0, ack}, 32'h0);
        end else begin
          if (!p_wr[w]) m_rdata = rd;
          check_value("ack_port", {30'h0, ack}, {30'h0, onehot(w)});
          check_value("err_ok", {31'h0, err}, 32'h0);
          check_value("ctl_cleared", {24'h0, eng_control}, 32'h0);
          check_value("rdata", {24'h0, rdata}, {24'h0, m_rdata});
          check_value("grant_cleared", {30'h0, grant_debug}, 32'h0);
          last_port = w;
          pending[w] = 1'b0;
          req[w] = 1'b0;
        end
      end
    end
    @(negedge clk);
    check_value("idle_ack", {30'h0, ack}, 32'h0);
    check_value("idle_grant", {30'h0, grant_debug}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; req_wr = 2'b00;
    req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
    eng_rdata = '0; eng_control_reset_n = 1'b1;
    pending = 2'b00; last_port = 1; m_rdata = '0;
    repeat (3) @(negedge clk);
    check_value("rst_ack", {30'h0, ack}, 32'h0);
    check_value("rst_err", {31'h0, err}, 32'h0);
    check_value("rst_rdata", {24'h0, rdata}, 32'h0);
    check_value("rst_control", {24'h0, eng_control}, 32'h0);
    check_value("rst_addr", {22'h0, eng_addr}, 32'h0);
    check_value("rst_wdata", {24'h0, eng_wdata}, 32'h0);
    check_value("rst_abort", {31'h0, eng_abort}, 32'h0);
    check_value("rst_grant", {30'h0, grant_debug}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Directed write on port 0, read on port 1, then contention.
    set_port(0, 1'b1, 10'h220, 8'h5A);
    serve_all(-1);
    set_port(1, 1'b0, 10'h22A, 8'h00);
    serve_all(8'hAA);
    for (int r = 0; r < 2; r++) begin
      set_random_port(0);
      set_random_port(1);
      serve_all(-1);
    end

    // Randomized rounds.
    for (int r = 0; r < 40; r++) begin
      int pats;
      pats = $urandom_range(1, 3);
      if (pats[0]) set_random_port(0);
      if (pats[1]) set_random_port(1);
      serve_all(-1);
    end

    // Spurious completion while idle.
    eng_control_reset_n = 1'b0;
    @(negedge clk);
    eng_control_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_value("spurious_ack", {30'h0, ack}, 32'h0);
      check_value("spurious_grant", {30'h0, grant_debug}, 32'h0);
    end
    set_random_port(1);
    serve_all(-1);

    // Reset in the middle of WAIT drops the cycle.
    set_random_port(0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_value("midrst_control", {24'h0, eng_control}, 32'h0);
    check_value("midrst_ack", {30'h0, ack}, 32'h0);
    check_value("midrst_grant", {30'h0, grant_debug}, 32'h0);
    reset = 1'b0; req = 2'b00; pending = 2'b00;
    last_port = 1; m_rdata = '0;
    eng_control_reset_n = 1'b0;
    @(negedge clk);
    eng_control_reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_value("late_pulse_ack", {30'h0, ack}, 32'h0);
      check_value("late_pulse_grant", {30'h0, grant_debug}, 32'h0);
    end
    check_value("midrst_rdata", {24'h0, rdata}, 32'h0);
    set_random_port(0);
    set_random_port(1);
    serve_all(-1);

`ifdef BUS_TIMEOUT_EN
    // No completion: abort/err exactly 32 cycles after WAIT entry.
    set_port(0, 1'b0, 10'h300, 8'h00);
    repeat (2) @(negedge clk);
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      if (j == 31) check_value("to_ack_early", {30'h0, ack}, 32'h0);
    end
    check_value("to_ack", {30'h0, ack}, 32'h1);
    check_value("to_err", {31'h0, err}, 32'h1);
    check_value("to_abort", {31'h0, eng_abort}, 32'h1);
    check_value("to_rdata", {24'h0, rdata}, 32'hFF);
    check_value("to_control", {24'h0, eng_control}, 32'h0);
    req[0] = 1'b0; pending[0] = 1'b0; last_port = 0; m_rdata = 8'hFF;
    @(negedge clk);
    check_value("to_abort_pulse", {31'h0, eng_abort}, 32'h0);
    // Completion coinciding with the timeout cycle wins.
    set_port(1, 1'b0, 10'h301, 8'h00);
    repeat (2) @(negedge clk);
    for (int j = 1; j <= 32; j++) begin
      @(negedge clk);
      if (j == 30) begin eng_control_reset_n = 1'b0; eng_rdata = 8'h3C; end
      if (j == 31) eng_control_reset_n = 1'b1;
    end
    check_value("race_ack", {30'h0, ack}, 32'h2);
    check_value("race_err", {31'h0, err}, 32'h0);
    check_value("race_abort", {31'h0, eng_abort}, 32'h0);
    check_value("race_rdata", {24'h0, rdata}, 32'h3C);
    req[1] = 1'b0; pending[1] = 1'b0; last_port = 1; m_rdata = 8'h3C;
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/isa_bus_arbiter.md
Name: isa_bus_arbiter

Overview:
- Shares the single ISA I/O bus-cycle engine between two requesters: port 0 (host command path) and port 1 (DMA/refill path).
- Arbitrates with two-way round-robin, holds the engine command word until the engine's active-low control-reset completion pulse, and returns read data and an ack to the granted requester.
- Sits between the requester logic and the bus-cycle state machine; that state machine's command/strobe protocol is unchanged.

Parameters:
- ADDR_W, 10, ISA I/O address width.
- DATA_W, 8, data width.
- TIMEOUT_CYCLES, 32, cycles allowed from issue to completion (used only with BUS_TIMEOUT_EN); must be ≥ 16.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-requester request; held high until ack.
- req_wr  in  2  per-requester direction: 1 = write, 0 = read.
- req_addr0, req_addr1  in  ADDR_W each  per-requester address.
- req_wdata0, req_wdata1  in  DATA_W each  per-requester write data.
- ack  out  2  one-cycle completion pulse to the granted requester.
- err  out  1  valid with ack; 1 = timed-out cycle (always 0 without BUS_TIMEOUT_EN).
- rdata  out  DATA_W  read data; valid in the ack cycle of a read.
- eng_control  out  8  engine command: bit0 = read, bit1 = write, bits 7:2 = 0.
- eng_addr  out  ADDR_W  address presented to the engine's address latch.
- eng_wdata  out  DATA_W  data presented to the engine's data latch.
- eng_rdata  in  DATA_W  engine read-data latch output.
- eng_control_reset_n  in  1  engine's active-low completion pulse.
- eng_abort  out  1  one-cycle pulse forcing the engine to idle (timeout only).
- grant_debug  out  2  one-hot current grant; 00 when idle.

Behaviour:
- Reset (synchronous, active-high) clears all outputs to 0, state to IDLE, and the round-robin pointer to "port 0 preferred". Reset mid-cycle drops the transaction with no ack.
- States:
  - IDLE: if any req is high, select a winner and go to ISSUE. Latch eng_addr/eng_wdata from the winner in the same edge.
  - ISSUE: drive eng_control = {6'b0, wr, ~wr}; go to WAIT.
  - WAIT: hold eng_control, eng_addr and eng_wdata stable. When eng_control_reset_n == 0: clear eng_control, capture rdata <= eng_rdata (reads only; rdata keeps its old value on writes), pulse ack[winner], go to IDLE.
- Arbitration:
  - If only one req is high, it wins.
  - If both are high, the port not granted last wins. The pointer updates only on ack.
- Latency: from req high in IDLE to eng_control nonzero is 2 cycles. From completion pulse to ack is 1 cycle.
- No back-to-back grant: IDLE always lasts at least 1 cycle between transactions, so the engine sees eng_control = 0 before the next command.
- A requester dropping req before ack is a protocol violation. The transaction still completes and the ack is still pulsed.
- A completion pulse seen outside WAIT is ignored.
- eng_control_reset_n low in the same cycle as the ISSUE→WAIT transition is honoured in WAIT on the next cycle. The engine holds the pulse for 1 cycle, so the arbiter samples it registered.
  - Implementation: sample eng_control_reset_n into a flop; WAIT uses the flopped value.
  - This adds 1 cycle to completion.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- With it defined:
  - A counter loads 0 on entry to WAIT and increments each WAIT cycle.
  - If the count reaches TIMEOUT_CYCLES-1 without completion: pulse eng_abort, clear eng_control, pulse ack and err, set rdata = all-ones, advance the pointer, go to IDLE.
  - If completion and timeout occur in the same cycle, completion wins (err = 0).
- Without it: no counter; eng_abort tied 0; err tied 0; WAIT waits indefinitely.

Decomposition:
- Shared package isa_bus_pkg:
  - state encoding localparams ARB_IDLE/ARB_ISSUE/ARB_WAIT;
  - command bit positions CMD_READ_BIT = 0, CMD_WRITE_BIT = 1;
  - default ADDR_W/DATA_W.
- One natural sub-module: isa_rr_arb2, a combinational two-way round-robin picker with a registered last-grant pointer (inputs req[1:0], ack_fire; output winner).

Test Plan:
- Single write: port0 req=1, wr=1, addr=0x220, wdata=0x5A → eng_control=0x02 two cycles later with eng_addr=0x220, eng_wdata=0x5A. Completion pulse → ack=01 one registered cycle later; eng_control=0.
- Single read: port1 addr=0x22A, eng_rdata=0xAA → eng_control=0x01. After completion, ack=10, rdata=0xAA in the same cycle.
- Contention: both req held for 4 transactions → grant order 0,1,0,1; IDLE ≥ 1 cycle between commands.
- Reset mid-WAIT: assert reset in WAIT → next cycle eng_control=0, ack=00, grant_debug=00. Late completion pulse is ignored.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=32): no completion → eng_abort, ack and err pulse exactly 32 cycles after WAIT entry; rdata=0xFF. Completion on cycle 32 → err=0.
- Spurious completion: eng_control_reset_n pulse while IDLE → no ack, state stays IDLE.
